// File: rtl/ttc_pkg.sv
// Shared definitions for the TTC frame aligner: state encoding, default sync
// pattern and a saturating counter helper.
package ttc_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } ttc_state_e;

  localparam logic [15:0] TTC_SYNC_DEFAULT = 16'h817E;

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32'd32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/ttc_frame_aligner_if.sv
// Serial-in / aligned-word-out bundle between the CDR stage and the command
// decoder. The master side feeds bits; the slave side is the aligner.
interface ttc_frame_aligner_if #(
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned ERR_W   = 8
);

  logic               datain;
  logic               bit_valid;
  logic               realign;
  logic [FRAME_W-1:0] data;
  logic               valid;
  logic               is_sync;
  logic               locked;
  logic [1:0]         state;
  logic [ERR_W-1:0]   err_cnt;

  modport master (
    output datain, bit_valid, realign,
    input  data, valid, is_sync, locked, state, err_cnt
  );

  modport slave (
    input  datain, bit_valid, realign,
    output data, valid, is_sync, locked, state, err_cnt
  );

endinterface

// File: rtl/ttc_sync_fsm.sv
// Alignment supervisor: hunt / confirm / locked state, sync and no-sync
// frame counters, and the lock / loss-of-lock decisions.
module ttc_sync_fsm
  import ttc_pkg::*;
#(
  parameter int unsigned LOCK_THRESH = 4,
  parameter int unsigned SYNC_PERIOD = 0
) (
  input  logic       clk160,
  input  logic       rst,
  input  logic       hunt_match_i,
  input  logic       frame_done_i,
  input  logic       word_sync_i,
  input  logic       realign_i,
  output ttc_state_e state_o,
  output logic       emit_o,
  output logic       err_o
);

  localparam int unsigned NS_W = (SYNC_PERIOD < 2) ? 1 : $clog2(SYNC_PERIOD + 1);

  ttc_state_e      state_q, state_d;
  logic [3:0]      synccnt_q, synccnt_d;
  logic [NS_W-1:0] nosync_q, nosync_d;

  always_ff @(posedge clk160) begin
    if (!rst) begin
      state_q   <= ST_HUNT;
      synccnt_q <= '0;
      nosync_q  <= '0;
    end else begin
      state_q   <= state_d;
      synccnt_q <= synccnt_d;
      nosync_q  <= nosync_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    synccnt_d = synccnt_q;
    nosync_d  = nosync_q;
    emit_o    = 1'b0;
    err_o     = 1'b0;

    if (realign_i) begin
      state_d   = ST_HUNT;
      synccnt_d = '0;
      nosync_d  = '0;
    end else begin
      unique case (state_q)
        ST_HUNT: begin
          if (hunt_match_i) begin
            synccnt_d = 4'd1;
            nosync_d  = '0;
            state_d   = (LOCK_THRESH == 1) ? ST_LOCKED : ST_CONFIRM;
          end
        end

        ST_CONFIRM: begin
          if (frame_done_i) begin
            if (word_sync_i) begin
              synccnt_d = synccnt_q + 4'd1;
              if (synccnt_d == 4'(LOCK_THRESH)) state_d = ST_LOCKED;
            end else begin
              state_d   = ST_HUNT;
              synccnt_d = '0;
              err_o     = 1'b1;
            end
          end
        end

        ST_LOCKED: begin
          if (frame_done_i) begin
            // The frame is always presented; loss of lock takes effect afterwards.
            emit_o = 1'b1;
            if (SYNC_PERIOD != 0) begin
              if (word_sync_i) begin
                nosync_d = '0;
              end else begin
                nosync_d = nosync_q + NS_W'(1);
                if (nosync_d == NS_W'(SYNC_PERIOD)) begin
                  state_d   = ST_HUNT;
                  nosync_d  = '0;
                  synccnt_d = '0;
                  err_o     = 1'b1;
                end
              end
            end
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/ttc_frame_aligner.sv
// TTC serial frame aligner: bit-level sync hunt, multi-frame confirmation and
// aligned word output with lock supervision and a saturating error count.
module ttc_frame_aligner
  import ttc_pkg::*;
#(
  parameter int unsigned        FRAME_W     = 16,
  parameter logic [FRAME_W-1:0] SYNC_WORD   = FRAME_W'(TTC_SYNC_DEFAULT),
  parameter int unsigned        LOCK_THRESH = 4,
  parameter int unsigned        SYNC_PERIOD = 0,
  parameter bit                 DROP_SYNC   = 1'b0,
  parameter int unsigned        ERR_W       = 8
) (
  input logic clk160,
  input logic rst,
  ttc_frame_aligner_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FRAME_W);

  // Only FRAME_W-1 history bits are stored; the incoming bit completes the word.
  logic [FRAME_W-2:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               is_sync_q, is_sync_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic [FRAME_W-1:0] word;
  logic               word_sync;
  logic               frame_done;
  logic               hunt_match;
  logic               emit;
  logic               fsm_err;
  ttc_state_e         state;

  assign word       = {shreg_q, bus.datain};
  assign word_sync  = (word == SYNC_WORD);
  assign hunt_match = bus.bit_valid && word_sync;
  assign frame_done = bus.bit_valid && (state != ST_HUNT) &&
                      (bitcnt_q == CNT_W'(FRAME_W - 1));

  ttc_sync_fsm #(
    .LOCK_THRESH (LOCK_THRESH),
    .SYNC_PERIOD (SYNC_PERIOD)
  ) u_fsm (
    .clk160       (clk160),
    .rst          (rst),
    .hunt_match_i (hunt_match),
    .frame_done_i (frame_done),
    .word_sync_i  (word_sync),
    .realign_i    (bus.realign),
    .state_o      (state),
    .emit_o       (emit),
    .err_o        (fsm_err)
  );

  always_comb begin
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    is_sync_d = 1'b0;
    err_cnt_d = err_cnt_q;

    if (bus.bit_valid) shreg_d = word[FRAME_W-2:0];

    if (bus.realign || (state == ST_HUNT)) begin
      bitcnt_d = '0;
    end else if (bus.bit_valid) begin
      bitcnt_d = frame_done ? '0 : (bitcnt_q + CNT_W'(1));
    end

    if (emit && !(DROP_SYNC && word_sync)) begin
      data_d    = word;
      valid_d   = 1'b1;
      is_sync_d = word_sync;
    end

    if (fsm_err) err_cnt_d = ERR_W'(sat_inc(32'(err_cnt_q), ERR_W));
  end

  always_ff @(posedge clk160) begin
    if (!rst) begin
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      is_sync_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      is_sync_q <= is_sync_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.data    = data_q;
  assign bus.valid   = valid_q;
  assign bus.is_sync = is_sync_q;
  assign bus.locked  = (state == ST_LOCKED);
  assign bus.state   = state;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ttc_frame_aligner.sv
// Directed bench for ttc_frame_aligner: instance A uses the defaults, instance B
// has SYNC_PERIOD=8 and DROP_SYNC=1; both see the same serial stream.
module tb_ttc_frame_aligner;

  localparam logic [15:0] SYNC = 16'h817E;

  logic clk160 = 1'b0;
  always #5 clk160 = ~clk160;

  logic rst;
  logic datain;
  logic bit_valid;
  logic realign;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  ttc_frame_aligner_if #(.FRAME_W(16), .ERR_W(8)) if_a ();
  ttc_frame_aligner_if #(.FRAME_W(16), .ERR_W(8)) if_b ();

  assign if_a.datain    = datain;
  assign if_a.bit_valid = bit_valid;
  assign if_a.realign   = realign;
  assign if_b.datain    = datain;
  assign if_b.bit_valid = bit_valid;
  assign if_b.realign   = realign;

  ttc_frame_aligner #(
    .FRAME_W(16), .SYNC_WORD(SYNC), .LOCK_THRESH(4),
    .SYNC_PERIOD(0), .DROP_SYNC(1'b0), .ERR_W(8)
  ) dut_a (.clk160(clk160), .rst(rst), .bus(if_a));

  ttc_frame_aligner #(
    .FRAME_W(16), .SYNC_WORD(SYNC), .LOCK_THRESH(4),
    .SYNC_PERIOD(8), .DROP_SYNC(1'b1), .ERR_W(8)
  ) dut_b (.clk160(clk160), .rst(rst), .bus(if_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk160);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_state"},  32'(if_a.state),   32'd0);
    chk({tag, "_locked"}, 32'(if_a.locked),  32'd0);
    chk({tag, "_valid"},  32'(if_a.valid),   32'd0);
    chk({tag, "_data"},   32'(if_a.data),    32'h0000);
    chk({tag, "_err"},    32'(if_a.err_cnt), 32'd0);
  endtask

  // Send bits w[hi] down to w[lo], each followed by 'gap' idle cycles. On bit 0
  // the frame-end expectations apply; everywhere else A must not strobe valid.
  task automatic send_part(input logic [15:0] w, input int hi, input int lo, input int gap,
                           input logic av, input logic bchk, input logic bv);
    for (int i = hi; i >= lo; i--) begin
      datain    = w[i];
      bit_valid = 1'b1;
      tick();
      if (i == 0) begin
        chk("A_valid_end", 32'(if_a.valid), 32'(av));
        if (av) begin
          chk("A_data", 32'(if_a.data), 32'(w));
          chk("A_is_sync", 32'(if_a.is_sync), 32'(w == SYNC));
        end
        if (bchk) begin
          chk("B_valid_end", 32'(if_b.valid), 32'(bv));
          if (bv) begin
            chk("B_data", 32'(if_b.data), 32'(w));
            chk("B_is_sync", 32'(if_b.is_sync), 32'd0);
          end
        end
      end else begin
        chk("A_valid_midframe", 32'(if_a.valid), 32'd0);
      end
      bit_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("A_valid_gap", 32'(if_a.valid), 32'd0);
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int gap, input logic av);
    send_part(w, 15, 0, gap, av, 1'b0, 1'b0);
  endtask

  // 5 junk bits, 6 syncs, then two data words; first match lands on bit 21.
  task automatic run_lock_seq(input int gap, input logic [7:0] exp_err);
    send_part(16'h0016, 4, 0, gap, 1'b0, 1'b0, 1'b0);
    send_part(SYNC, 15, 1, gap, 1'b0, 1'b0, 1'b0);
    chk("A_state_bit20", 32'(if_a.state), 32'd0);
    send_part(SYNC, 0, 0, gap, 1'b0, 1'b0, 1'b0);
    chk("A_state_bit21", 32'(if_a.state), 32'd1);
    send_word(SYNC, gap, 1'b0);
    send_word(SYNC, gap, 1'b0);
    chk("A_state_sync3", 32'(if_a.state), 32'd1);
    chk("A_locked_sync3", 32'(if_a.locked), 32'd0);
    send_word(SYNC, gap, 1'b0);
    chk("A_state_sync4", 32'(if_a.state), 32'd2);
    chk("A_locked_sync4", 32'(if_a.locked), 32'd1);
    send_word(SYNC, gap, 1'b1);
    send_word(SYNC, gap, 1'b1);
    send_word(16'hF0F0, gap, 1'b1);
    send_word(16'hF0F1, gap, 1'b1);
    chk("A_err_lockseq", 32'(if_a.err_cnt), 32'(exp_err));
  endtask

  task automatic do_realign(input logic [7:0] exp_err);
    realign   = 1'b1;
    bit_valid = 1'b0;
    tick();
    realign = 1'b0;
    chk("A_state_realign", 32'(if_a.state), 32'd0);
    chk("A_locked_realign", 32'(if_a.locked), 32'd0);
    chk("A_err_realign", 32'(if_a.err_cnt), 32'(exp_err));
  endtask

  initial begin
    rst       = 1'b0;
    datain    = 1'b0;
    bit_valid = 1'b1;
    realign   = 1'b0;

    // Reset held for 3 cycles with data toggling
    for (int c = 0; c < 3; c++) begin
      datain = ~datain;
      tick();
      chk_reset_a("reset");
    end
    rst       = 1'b1;
    bit_valid = 1'b0;

    // Lock with misalignment, continuous bits
    run_lock_seq(0, 8'd0);
    do_realign(8'd0);

    // Corrupted confirm: sync, sync, 0x817F, then four syncs
    send_word(SYNC, 0, 1'b0);
    chk("A_state_cc1", 32'(if_a.state), 32'd1);
    send_word(SYNC, 0, 1'b0);
    chk("A_state_cc2", 32'(if_a.state), 32'd1);
    send_word(16'h817F, 0, 1'b0);
    chk("A_state_cc_bad", 32'(if_a.state), 32'd0);
    chk("A_err_cc_bad", 32'(if_a.err_cnt), 32'd1);
    for (int k = 0; k < 3; k++) begin
      send_word(SYNC, 0, 1'b0);
      chk("A_state_cc_reconfirm", 32'(if_a.state), 32'd1);
    end
    send_word(SYNC, 0, 1'b0);
    chk("A_state_cc_relock", 32'(if_a.state), 32'd2);
    chk("A_locked_cc_relock", 32'(if_a.locked), 32'd1);
    do_realign(8'd1);

    // Gated bits: one qualified bit every 4 cycles
    run_lock_seq(3, 8'd1);
    do_realign(8'd1);

    // Fresh start for the loss-of-lock case
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_reset_a("reset_pulse");

    for (int k = 0; k < 4; k++) send_part(SYNC, 15, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("B_state_lol_lock", 32'(if_b.state), 32'd2);
    chk("A_state_lol_lock", 32'(if_a.state), 32'd2);
    send_part(SYNC, 15, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("B_data_hold_dropped_sync", 32'(if_b.data), 32'h0000);
    for (int k = 0; k < 8; k++) begin
      send_part(16'hA5A0 + 16'(k), 15, 0, 0, 1'b1, 1'b1, 1'b1);
      if (k < 7) chk("B_locked_lol_pre", 32'(if_b.locked), 32'd1);
    end
    chk("B_locked_lol", 32'(if_b.locked), 32'd0);
    chk("B_state_lol", 32'(if_b.state), 32'd0);
    chk("B_err_lol", 32'(if_b.err_cnt), 32'd1);
    chk("A_locked_no_lol", 32'(if_a.locked), 32'd1);
    chk("A_err_no_lol", 32'(if_a.err_cnt), 32'd0);

    // Realign at bit 7 of a locked frame
    send_part(16'h0000, 15, 9, 0, 1'b0, 1'b0, 1'b0);
    realign   = 1'b1;
    datain    = 1'b0;
    bit_valid = 1'b1;
    tick();
    realign = 1'b0;
    chk("A_state_midrealign", 32'(if_a.state), 32'd0);
    chk("A_locked_midrealign", 32'(if_a.locked), 32'd0);
    send_part(16'h0000, 7, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("A_err_midrealign", 32'(if_a.err_cnt), 32'd0);
    chk("A_data_midrealign", 32'(if_a.data), 32'hA5A7);

    // Re-lock with one corrupted confirm, then reset at bit 7
    send_word(SYNC, 0, 1'b0);
    send_word(16'h817F, 0, 1'b0);
    chk("A_err_prereset", 32'(if_a.err_cnt), 32'd1);
    for (int k = 0; k < 4; k++) send_word(SYNC, 0, 1'b0);
    chk("A_state_prereset", 32'(if_a.state), 32'd2);
    send_part(16'h0000, 15, 9, 0, 1'b0, 1'b0, 1'b0);
    rst       = 1'b0;
    realign   = 1'b1;
    datain    = 1'b1;
    bit_valid = 1'b1;
    tick();
    rst       = 1'b1;
    realign   = 1'b0;
    bit_valid = 1'b0;
    chk_reset_a("midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ttc_frame_aligner.md
Name: ttc_frame_aligner

Overview:
- Parametrised successor to the fixed 16-bit TTC serial receiver path.
- Takes the recovered serial bit stream, one bit per qualified clock, and hunts for a programmable sync word at any bit offset.
- Confirms the alignment over several frames, then emits aligned parallel words with a valid strobe.
- Sits between the clock/data recovery stage and the TTC command decoder. Adds lock/loss-of-lock supervision and error counting, which the previous generation lacked.

Parameters:
- FRAME_W, 16, frame width in bits (4..32).
- SYNC_WORD, 16'h817E, alignment pattern (FRAME_W bits), MSB first on the wire.
- LOCK_THRESH, 4, consecutive aligned sync words needed to declare lock (1..15).
- SYNC_PERIOD, 0, max frames in LOCKED without a sync word before lock is lost; 0 disables the check.
- DROP_SYNC, 0, 1 = sync words received in LOCKED are not presented on data/valid.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk160 input 1: block clock.
- rst input 1: synchronous reset, active-low.
- datain input 1: serial data bit, MSB of each frame first.
- bit_valid input 1: datain is sampled only on edges where this is 1.
- realign input 1: synchronous request to drop alignment and re-hunt.
- data output FRAME_W: aligned frame word.
- valid output 1: one-cycle strobe, data is new.
- is_sync output 1: qualifies valid; the word equals SYNC_WORD.
- locked output 1: high in LOCKED.
- state output 2: 0 HUNT, 1 CONFIRM, 2 LOCKED.
- err_cnt output ERR_W: saturating count of alignment failures.

Behaviour:
- Reset (rst=0 at an edge):
  - state=HUNT, shift register=0, bit and frame counters=0.
  - data=0, valid=0, is_sync=0, locked=0, err_cnt=0.
  - Reset overrides realign and applies mid-frame or in any state.
- Shift: on an edge with bit_valid=1, next word = {shreg[FRAME_W-2:0], datain}.
  - With bit_valid=0, all state and counters hold; valid drops to 0 after one cycle.
- HUNT:
  - Each qualified bit, compare the next word with SYNC_WORD.
  - On a match: bitcnt=0, synccnt=1, go to CONFIRM. If LOCK_THRESH=1, go straight to LOCKED.
- CONFIRM:
  - bitcnt counts 0..FRAME_W-1 on qualified bits. A frame completes when bitcnt=FRAME_W-1 and bit_valid=1.
  - Complete word == SYNC_WORD: synccnt++. On reaching LOCK_THRESH, go to LOCKED on that edge; locked=1 from the next cycle.
  - Mismatch: go to HUNT and increment err_cnt. The hunt resumes on the next qualified bit; the mismatching word is not re-searched.
  - No data/valid output in HUNT or CONFIRM.
- LOCKED:
  - On each frame completion, on the same edge: data=word, valid=1 for exactly one cycle, is_sync=(word==SYNC_WORD).
  - If DROP_SYNC=1 and the word is a sync word, valid stays 0 and data holds.
  - Latency: valid is high in the cycle after the edge that samples the last bit.
- Loss of lock (SYNC_PERIOD>0):
  - nosync counter is cleared by a sync frame and incremented by each non-sync frame.
  - When it reaches SYNC_PERIOD: the current frame is still output, then go to HUNT, locked=0, err_cnt++.
- realign=1 at any edge: go to HUNT, clear counters, locked=0.
  - A frame completing on the same edge is discarded (valid=0).
  - err_cnt is not incremented.
- err_cnt saturates at all-ones.
- Simultaneous events: reset beats realign, realign beats frame completion, and loss of lock is evaluated after output.

Decomposition:
- Package ttc_pkg holds:
  - state encoding constants (HUNT/CONFIRM/LOCKED);
  - the default SYNC_WORD;
  - a shared saturating-increment function.
- One natural sub-module: ttc_sync_fsm, containing the state register, synccnt and nosync counters, and lock decisions.
- The top module keeps the shift register, bitcnt, output registers and err_cnt.

Test Plan:
- Reset: hold rst=0 for 3 cycles with datain toggling -> state=0, locked=0, valid=0, data=0x0000, err_cnt=0 throughout.
- Lock with misalignment (defaults, bit_valid=1): send 5 junk bits, then 0x817E ×6, then 0xF0F0, 0xF0F1 -> first match after the 21st bit; locked after the 4th sync; valid pulses for syncs 5 and 6 with is_sync=1, then data 0xF0F0 and 0xF0F1 with is_sync=0, each 16 cycles apart; err_cnt=0.
- Corrupted confirm: send sync, sync, 0x817F, then sync ×4 -> returns to HUNT at the 3rd frame with err_cnt=1; re-locks on the 4th following sync; no valid before lock.
- Gated bits: bit_valid=1 once every 4 cycles with the stream from the lock-with-misalignment case -> identical word sequence; valid pulses 64 cycles apart, each for 1 cycle.
- Loss of lock (SYNC_PERIOD=8, DROP_SYNC=1): after lock, send 8 data words and no sync -> 8 valid pulses, no valid for syncs; locked falls after the 8th word; err_cnt=1.
- Mid-frame interrupts: realign at bit 7 of a LOCKED frame -> state=0 next cycle, no valid for that frame, err_cnt unchanged. A repeat with rst=0 instead -> all outputs at reset values.
